booth_sequencer: RTL and testbench

BOOTH_SEQUENCER -- requirements
Module: booth_sequencer

---
 rtl/booth_sequencer_if.sv | 40 ++++
 rtl/booth_sequencer.sv | 119 +++++++++++
 tb/tb_booth_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/booth_sequencer_if.sv
// ---------------------------------------------------------------------------
// booth_sequencer_if
//   Groups the control handshake between the Booth multiply sequencer and
//   its datapath/requester.
//
//   Parameter WIDTH : operand width (number of Booth iterations), 2..32.
//
//   Requester/datapath -> sequencer : start, abort, q0, q_m1
//   Sequencer -> datapath/requester : load, add, sub, shift, busy, eq, done,
//                                     count[$clog2(WIDTH)-1:0]
//
//   modport slave  : the sequencer side
//   modport master : the datapath / requester side
// ---------------------------------------------------------------------------
interface booth_sequencer_if #(
  parameter int WIDTH = 8
);
  logic                     start;
  logic                     abort;
  logic                     q0;
  logic                     q_m1;
  logic                     load;
  logic                     add;
  logic                     sub;
  logic                     shift;
  logic                     busy;
  logic                     eq;
  logic                     done;
  logic [$clog2(WIDTH)-1:0] count;

  modport slave (
    input  start, abort, q0, q_m1,
    output load, add, sub, shift, busy, eq, done, count
  );

  modport master (
    output start, abort, q0, q_m1,
    input  load, add, sub, shift, busy, eq, done, count
  );
endinterface

// File: rtl/booth_sequencer.sv
// ---------------------------------------------------------------------------
// booth_sequencer
//   Moore FSM that sequences a radix-2 Booth multiply on an external
//   datapath holding {A, Q, Q(-1)} and M.
//
//   Parameter WIDTH : operand width / number of iterations, 2..32.
//
//   Ports:
//     sys_clock : single clock, rising edge
//     reset_n   : asynchronous active-low reset
//     bus       : booth_sequencer_if.slave
//                   in : start (level request), abort, q0, q_m1
//                   out: load, add, sub, shift, busy, eq, done, count
//
//   Optional feature: define BOOTH_ABORT_EN to make abort cancel a running
//   multiply (goes to WAIT_REL, count cleared, no done pulse). Without the
//   macro the abort input is accepted but ignored.
// ---------------------------------------------------------------------------
module booth_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic               sys_clock,
  input  logic               reset_n,
  booth_sequencer_if.slave   bus
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOAD     = 3'd1;
  localparam logic [2:0] EVAL     = 3'd2;
  localparam logic [2:0] ADDSUB   = 3'd3;
  localparam logic [2:0] SHIFT    = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;
  localparam logic [2:0] WAIT_REL = 3'd6;

  logic [2:0]    state;
  logic [2:0]    state_next;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [1:0]    pair;
  logic          busy_int;
  logic          abort_hit;

  assign busy_int = (state != IDLE) && (state != WAIT_REL);

`ifdef BOOTH_ABORT_EN
  assign abort_hit = bus.abort && busy_int;
`else
  logic unused_abort;
  assign unused_abort = bus.abort;
  assign abort_hit    = 1'b0;
`endif

  // Next-state and iteration-count logic. Abort overrides every other
  // transition so it is applied last.
  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = LOAD;
          count_next = '0;
        end
      end
      LOAD: begin
        state_next = EVAL;
        count_next = '0;
      end
      // 01 or 10 needs an add/sub before the shift; 00/11 shift directly.
      EVAL:     state_next = (bus.q0 ^ bus.q_m1) ? ADDSUB : SHIFT;
      ADDSUB:   state_next = SHIFT;
      SHIFT: begin
        if (count == LAST) begin
          state_next = DONE;
        end else begin
          state_next = EVAL;
          count_next = count + CW'(1);
        end
      end
      DONE:     state_next = WAIT_REL;
      // Held start must drop before another multiply can be requested.
      WAIT_REL: if (!bus.start) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
    if (abort_hit) begin
      state_next = WAIT_REL;
      count_next = '0;
    end
  end

  // State, counter and the Booth pair captured in EVAL so ADDSUB acts on
  // the bits that were evaluated, not on whatever the datapath shows later.
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
      pair  <= 2'b00;
    end else begin
      state <= state_next;
      count <= count_next;
      if (state == EVAL) begin
        pair <= {bus.q0, bus.q_m1};
      end
    end
  end

  assign bus.load  = (state == LOAD);
  assign bus.add   = (state == ADDSUB) && (pair == 2'b01);
  assign bus.sub   = (state == ADDSUB) && (pair == 2'b10);
  assign bus.shift = (state == SHIFT);
  assign bus.busy  = busy_int;
  assign bus.eq    = (state == SHIFT) && (count == LAST);
  assign bus.done  = (state == DONE);
  assign bus.count = count;

endmodule

// File: tb/tb_booth_sequencer.sv
// ---------------------------------------------------------------------------
// tb_booth_sequencer
//   Directed bench for booth_sequencer (WIDTH = 8) with a small Booth
//   datapath model driven by the sequencer's commands.
// ---------------------------------------------------------------------------
module tb_booth_sequencer;

  localparam int WIDTH = 8;

  logic sys_clock;
  logic reset_n;

  int pass_count  = 0;
  int check_count = 0;

  booth_sequencer_if #(.WIDTH(WIDTH)) bus ();

  booth_sequencer #(.WIDTH(WIDTH)) dut (
    .sys_clock (sys_clock),
    .reset_n   (reset_n),
    .bus       (bus)
  );

  initial sys_clock = 1'b0;
  always #5 sys_clock = ~sys_clock;

  // Datapath model: {A, Q, Q(-1)} and M, updated from the command outputs.
  logic [7:0] mplier_reg;
  logic [7:0] mcand_reg;
  logic [7:0] dp_a;
  logic [7:0] dp_q;
  logic [7:0] dp_m;
  logic       dp_qm1;

  always @(posedge sys_clock) begin
    if (bus.load) begin
      dp_a   <= 8'h00;
      dp_q   <= mplier_reg;
      dp_m   <= mcand_reg;
      dp_qm1 <= 1'b0;
    end else if (bus.add) begin
      dp_a <= dp_a + dp_m;
    end else if (bus.sub) begin
      dp_a <= dp_a - dp_m;
    end else if (bus.shift) begin
      {dp_a, dp_q, dp_qm1} <= {dp_a[7], dp_a, dp_q};
    end
  end

  assign bus.q0   = dp_q[0];
  assign bus.q_m1 = dp_qm1;

  // One complete multiply. start is high for 'hold' cycles. Returns the
  // product, LOAD-to-done latency, done/load counts, iterations that saw
  // add/sub, whether eq fell as done rose, and state sampled at t == hold.
  task automatic run_multiply(
    input  logic [7:0]  mplier,
    input  logic [7:0]  mcand,
    input  int          hold,
    output logic [15:0] product,
    output int          latency,
    output int          done_pulses,
    output int          load_pulses,
    output logic [7:0]  add_mask,
    output logic [7:0]  sub_mask,
    output logic        eq_ok,
    output logic [2:0]  state_at_hold
  );
    int   load_t;
    int   done_t;
    logic prev_eq;
    load_t        = -1;
    done_t        = -1;
    latency       = -1;
    done_pulses   = 0;
    load_pulses   = 0;
    add_mask      = 8'h00;
    sub_mask      = 8'h00;
    eq_ok         = 1'b0;
    prev_eq       = 1'b0;
    state_at_hold = 3'bxxx;
    mplier_reg    = mplier;
    mcand_reg     = mcand;
    @(negedge sys_clock);
    bus.start = 1'b1;
    for (int t = 1; t <= 100; t++) begin
      @(negedge sys_clock);
      if (t == hold) begin
        state_at_hold = dut.state;
        bus.start     = 1'b0;
      end
      if (bus.load) begin
        load_pulses++;
        if (load_t < 0) load_t = t;
      end
      if (bus.add) add_mask[bus.count] = 1'b1;
      if (bus.sub) sub_mask[bus.count] = 1'b1;
      if (bus.done) begin
        done_pulses++;
        if (done_t < 0) begin
          done_t  = t;
          latency = t - load_t;
          eq_ok   = prev_eq && !bus.eq;
        end
      end
      prev_eq = bus.eq;
      if (done_t >= 0 && t >= hold + 1 && t >= done_t + 2) break;
    end
    bus.start = 1'b0;
    product   = {dp_a, dp_q};
  endtask

  task automatic test_reset();
    #3 reset_n = 1'b0;
    #1;
    check_count++;
    if ({bus.load, bus.add, bus.sub, bus.shift, bus.busy, bus.eq, bus.done} !== 7'b0) begin
      $display("[TB] FAIL reset_outputs: got %b expected %b",
               {bus.load, bus.add, bus.sub, bus.shift, bus.busy, bus.eq, bus.done}, 7'b0);
    end else pass_count++;
    check_count++;
    if (bus.count !== 3'd0) begin
      $display("[TB] FAIL reset_count: got %0d expected 0", bus.count);
    end else pass_count++;
    check_count++;
    if (dut.state !== 3'd0) begin
      $display("[TB] FAIL reset_state: got %0d expected 0 (IDLE)", dut.state);
    end else pass_count++;
    repeat (2) @(negedge sys_clock);
    reset_n = 1'b1;
  endtask

  task automatic test_basic_7x7();
    logic [15:0] p;
    int lat, dn, ld;
    logic [7:0] am, sm;
    logic eqk;
    logic [2:0] st;
    run_multiply(8'h07, 8'h07, 2, p, lat, dn, ld, am, sm, eqk, st);
    check_count++;
    if (dn !== 1) $display("[TB] FAIL 7x7_done_pulses: got %0d expected 1", dn);
    else pass_count++;
    check_count++;
    if (lat !== 19) $display("[TB] FAIL 7x7_latency: got %0d expected 19", lat);
    else pass_count++;
    check_count++;
    if (sm !== 8'h01) $display("[TB] FAIL 7x7_sub_iters: got %b expected %b", sm, 8'h01);
    else pass_count++;
    check_count++;
    if (am !== 8'h08) $display("[TB] FAIL 7x7_add_iters: got %b expected %b", am, 8'h08);
    else pass_count++;
    check_count++;
    if (p !== 16'h0031) $display("[TB] FAIL 7x7_product: got %h expected 0031", p);
    else pass_count++;
  endtask

  task automatic test_negative_fc();
    logic [15:0] p;
    int lat, dn, ld;
    logic [7:0] am, sm;
    logic eqk;
    logic [2:0] st;
    run_multiply(8'hFC, 8'hFC, 2, p, lat, dn, ld, am, sm, eqk, st);
    check_count++;
    if (lat !== 18) $display("[TB] FAIL fc_latency: got %0d expected 18", lat);
    else pass_count++;
    check_count++;
    if (sm !== 8'h04) $display("[TB] FAIL fc_sub_iters: got %b expected %b", sm, 8'h04);
    else pass_count++;
    check_count++;
    if (am !== 8'h00) $display("[TB] FAIL fc_add_iters: got %b expected %b", am, 8'h00);
    else pass_count++;
    check_count++;
    if (p !== 16'h0010) $display("[TB] FAIL fc_product: got %h expected 0010", p);
    else pass_count++;
    check_count++;
    if (eqk !== 1'b1) $display("[TB] FAIL fc_eq_fall_at_done: got %b expected 1", eqk);
    else pass_count++;
  endtask

  task automatic test_back_to_back();
    logic [7:0]  mp [6] = '{8'h07, 8'hFC, 8'h07, 8'hFC, 8'h03, 8'h80};
    logic [7:0]  mc [6] = '{8'hFC, 8'h07, 8'h07, 8'hFC, 8'h05, 8'h01};
    logic [15:0] ex [6] = '{16'hFFE4, 16'hFFE4, 16'h0031, 16'h0010, 16'h000F, 16'hFF80};
    logic [15:0] p;
    int lat, dn, ld;
    logic [7:0] am, sm;
    logic eqk;
    logic [2:0] st;
    for (int i = 0; i < 6; i++) begin
      run_multiply(mp[i], mc[i], 2, p, lat, dn, ld, am, sm, eqk, st);
      check_count++;
      if (p !== ex[i]) begin
        $display("[TB] FAIL b2b_product_%0d: got %h expected %h", i, p, ex[i]);
      end else pass_count++;
    end
  endtask

  task automatic test_start_held();
    logic [15:0] p;
    int lat, dn, ld;
    logic [7:0] am, sm;
    logic eqk;
    logic [2:0] st;
    run_multiply(8'h07, 8'h07, 30, p, lat, dn, ld, am, sm, eqk, st);
    check_count++;
    if (dn !== 1) $display("[TB] FAIL held_done_pulses: got %0d expected 1", dn);
    else pass_count++;
    check_count++;
    if (ld !== 1) $display("[TB] FAIL held_load_pulses: got %0d expected 1", ld);
    else pass_count++;
    check_count++;
    if (st !== 3'd6) $display("[TB] FAIL held_state_wait_rel: got %0d expected 6", st);
    else pass_count++;
    check_count++;
    if (dut.state !== 3'd0) $display("[TB] FAIL held_release_idle: got %0d expected 0", dut.state);
    else pass_count++;
  endtask

  task automatic test_reset_midrun();
    logic [15:0] p;
    int lat, dn, ld;
    logic [7:0] am, sm;
    logic eqk;
    logic [2:0] st;
    bit found;
    found      = 1'b0;
    mplier_reg = 8'h07;
    mcand_reg  = 8'h07;
    @(negedge sys_clock);
    bus.start = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      @(negedge sys_clock);
      if (t == 2) bus.start = 1'b0;
      if (bus.add && bus.count == 3'd3) begin
        found = 1'b1;
        break;
      end
    end
    bus.start = 1'b0;
    check_count++;
    if (!found) $display("[TB] FAIL midrun_reach_addsub3: got 0 expected 1");
    else pass_count++;
    #2 reset_n = 1'b0;
    #1;
    check_count++;
    if ({bus.load, bus.add, bus.sub, bus.shift, bus.busy, bus.eq, bus.done} !== 7'b0) begin
      $display("[TB] FAIL midrun_reset_outputs: got %b expected %b",
               {bus.load, bus.add, bus.sub, bus.shift, bus.busy, bus.eq, bus.done}, 7'b0);
    end else pass_count++;
    check_count++;
    if (dut.state !== 3'd0 || bus.count !== 3'd0) begin
      $display("[TB] FAIL midrun_reset_state: got state %0d count %0d expected 0 0",
               dut.state, bus.count);
    end else pass_count++;
    @(negedge sys_clock);
    reset_n = 1'b1;
    run_multiply(8'h07, 8'h07, 2, p, lat, dn, ld, am, sm, eqk, st);
    check_count++;
    if (p !== 16'h0031) $display("[TB] FAIL midrun_rerun_product: got %h expected 0031", p);
    else pass_count++;
  endtask

  task automatic test_abort();
`ifdef BOOTH_ABORT_EN
    logic exp_busy  = 1'b0;
    int   exp_dones = 0;
`else
    logic exp_busy  = 1'b1;
    int   exp_dones = 1;
`endif
    bit   fired;
    bit   sampled;
    logic busy_after;
    int   dones;
    fired      = 1'b0;
    sampled    = 1'b0;
    busy_after = 1'bx;
    dones      = 0;
    mplier_reg = 8'h07;
    mcand_reg  = 8'h07;
    @(negedge sys_clock);
    bus.start = 1'b1;
    for (int t = 1; t <= 60; t++) begin
      @(negedge sys_clock);
      if (t == 2) bus.start = 1'b0;
      if (fired && !sampled) begin
        bus.abort  = 1'b0;
        busy_after = bus.busy;
        sampled    = 1'b1;
      end
      if (bus.done) dones++;
      if (!fired && bus.busy && bus.count == 3'd4) begin
        bus.abort = 1'b1;
        fired     = 1'b1;
      end
    end
    bus.abort = 1'b0;
    check_count++;
    if (busy_after !== exp_busy) begin
      $display("[TB] FAIL abort_busy_next: got %b expected %b", busy_after, exp_busy);
    end else pass_count++;
    check_count++;
    if (dones !== exp_dones) begin
      $display("[TB] FAIL abort_done_pulses: got %0d expected %0d", dones, exp_dones);
    end else pass_count++;
`ifndef BOOTH_ABORT_EN
    check_count++;
    if ({dp_a, dp_q} !== 16'h0031) begin
      $display("[TB] FAIL abort_ignored_product: got %h expected 0031", {dp_a, dp_q});
    end else pass_count++;
`endif
  endtask

  initial begin
    reset_n   = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    test_reset();
    test_basic_7x7();
    test_negative_fc();
    test_back_to_back();
    test_start_held();
    test_reset_midrun();
    test_abort();
    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
